// File: rtl/mux_pkg.sv
// Shared definitions for the mux_n_arb block.
//   MUX_MODE_SEL / MUX_MODE_RR : encodings of the i_mode input
//   mux_mode_e                 : enum view of the same encodings
package mux_pkg;
  localparam logic MUX_MODE_SEL = 1'b0;
  localparam logic MUX_MODE_RR  = 1'b1;

  typedef enum logic {
    MODE_SEL = MUX_MODE_SEL,
    MODE_RR  = MUX_MODE_RR
  } mux_mode_e;
endpackage

// File: rtl/mux_n_arb_rr_grant.sv
// rr_grant: combinational round-robin priority pick.
// Picks the first asserted req bit scanning upward from ptr, wrapping to 0.
// Ports:
//   req     [N-1:0]      request vector
//   ptr     [SEL_W-1:0]  scan start index (always < N)
//   gnt     [SEL_W-1:0]  granted index (0 when gnt_vld=0)
//   gnt_vld              a request was found
module rr_grant #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_vld
);
  int idx;

  // Walk offsets from farthest to nearest so the nearest hit wins last.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt     = SEL_W'(idx);
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_n_arb.sv
// mux_n_arb: N:1 multiplexer with a single-entry registered output and
// valid/ready on every input and on the output. Explicit-select or
// round-robin selection via i_mode.
// Optional: define MUX_N_ARB_SRC_TAG_EN to add o_src, the index of the
// input that produced the held beat.
// Ports:
//   i_clk, i_reset    clock (rising), async active-high reset
//   i_mode            0 explicit select, 1 round-robin
//   i_sel             input index for explicit select
//   i_data/i_valid    packed inputs (input k at [k*WIDTH +: WIDTH]), valids
//   o_ready           per-input ready, one-hot or zero
//   o_data/o_valid    registered output beat
//   i_ready           downstream ready
//   o_src             (optional) source index of the held beat
module mux_n_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_mode,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [NUM_IN-1:0]       i_valid,
  output logic [NUM_IN-1:0]       o_ready,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_valid,
`ifdef MUX_N_ARB_SRC_TAG_EN
  output logic [SEL_W-1:0]        o_src,
`endif
  input  logic                    i_ready
);
  mux_mode_e        mode;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_gnt, gnt;
  logic             rr_vld, sel_vld, gnt_vld;
  logic             accept, xfer;
  logic [WIDTH-1:0] din [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign din[k] = i_data[k*WIDTH +: WIDTH];
  end

  assign mode = mux_mode_e'(i_mode);

  rr_grant #(.N(NUM_IN), .SEL_W(SEL_W)) u_rr (
    .req     (i_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_vld (rr_vld)
  );

  // Range check comes first so an out-of-range i_sel never indexes i_valid.
  assign sel_vld = (int'(i_sel) < NUM_IN) && i_valid[i_sel];

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end else if (sel_vld) begin
      gnt     = i_sel;
      gnt_vld = 1'b1;
    end
  end

  // Output slot is free when empty or being popped this cycle.
  assign accept = !o_valid || i_ready;
  // A grant implies the granted input is valid, so grant+accept is a transfer.
  assign xfer   = gnt_vld && accept && !i_reset;

  always_comb begin
    o_ready = '0;
    if (xfer) o_ready = NUM_IN'(1) << gnt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (accept) begin
        o_valid <= xfer;
        if (xfer) o_data <= din[gnt];
      end
      if (xfer && mode == MODE_RR)
        rr_ptr <= (int'(gnt) == NUM_IN - 1) ? '0 : gnt + 1'b1;
    end
  end

`ifdef MUX_N_ARB_SRC_TAG_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   o_src <= '0;
    else if (xfer) o_src <= gnt;
  end
`endif
endmodule

// File: tb/tb_mux_n_arb.sv
// Directed bench for mux_n_arb: an 8-input instance for the main function
// and a 6-input instance for out-of-range select handling.
module tb_mux_n_arb;
  logic        clk, rst;
  // 8-input instance
  logic        mode, rdy;
  logic [2:0]  sel;
  logic [255:0] data;
  logic [7:0]  vld, ordy;
  logic [31:0] odata;
  logic        ovld;
  // 6-input instance
  logic        mode6, rdy6;
  logic [2:0]  sel6;
  logic [191:0] data6;
  logic [5:0]  vld6, ordy6;
  logic [31:0] odata6;
  logic        ovld6;
`ifdef MUX_N_ARB_SRC_TAG_EN
  logic [2:0]  osrc, osrc6;
`endif

  int errors = 0;
  int checks = 0;

  mux_n_arb #(.WIDTH(32), .NUM_IN(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_sel(sel), .i_data(data),
    .i_valid(vld), .o_ready(ordy), .o_data(odata), .o_valid(ovld),
`ifdef MUX_N_ARB_SRC_TAG_EN
    .o_src(osrc),
`endif
    .i_ready(rdy));

  mux_n_arb #(.WIDTH(32), .NUM_IN(6)) dut6 (
    .i_clk(clk), .i_reset(rst), .i_mode(mode6), .i_sel(sel6), .i_data(data6),
    .i_valid(vld6), .o_ready(ordy6), .o_data(odata6), .o_valid(ovld6),
`ifdef MUX_N_ARB_SRC_TAG_EN
    .o_src(osrc6),
`endif
    .i_ready(rdy6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [31:0] v);
    data[k*32 +: 32] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 3'd0; vld = 8'hFF; rdy = 1'b1; data = '0;
    mode6 = 1'b0; sel6 = 3'd0; vld6 = 6'h3F; rdy6 = 1'b1; data6 = '0;
    #2;
    checks++; if (ordy !== 8'h00) begin errors++; $display("FAIL reset_ready got=%h exp=00", ordy); end
    step(); step();
    checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ovld); end
    checks++; if (odata !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", odata); end
    checks++; if (ovld6 !== 1'b0) begin errors++; $display("FAIL reset_valid6 got=%b exp=0", ovld6); end
`ifdef MUX_N_ARB_SRC_TAG_EN
    checks++; if (osrc !== 3'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", osrc); end
`endif
    vld = 8'h00; vld6 = 6'h00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_select();
    for (int k = 0; k < 8; k++) set_data(k, 32'h1000 + k);
    set_data(5, 32'hDEADBEEF);
    mode = 1'b0; sel = 3'd5; vld = 8'h20; rdy = 1'b1;
    #1;
    checks++; if (ordy !== 8'h20) begin errors++; $display("FAIL sel_ready got=%h exp=20", ordy); end
    step();
    checks++; if (ovld !== 1'b1) begin errors++; $display("FAIL sel_valid got=%b exp=1", ovld); end
    checks++; if (odata !== 32'hDEADBEEF) begin errors++; $display("FAIL sel_data got=%h exp=deadbeef", odata); end
    // Selected input not valid while others are: no grant, beat pops, data holds.
    vld = 8'hDF;
    #1;
    checks++; if (ordy !== 8'h00) begin errors++; $display("FAIL sel_novalid_ready got=%h exp=00", ordy); end
    step();
    checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL sel_pop_valid got=%b exp=0", ovld); end
    checks++; if (odata !== 32'hDEADBEEF) begin errors++; $display("FAIL sel_hold_data got=%h exp=deadbeef", odata); end
    vld = 8'h00;
  endtask

  task automatic test_sel_range();
    for (int k = 0; k < 6; k++) data6[k*32 +: 32] = 32'h600 + k;
    mode6 = 1'b0; vld6 = 6'h3F; rdy6 = 1'b1; sel6 = 3'd7;
    #1;
    checks++; if (ordy6 !== 6'h00) begin errors++; $display("FAIL range7_ready got=%h exp=00", ordy6); end
    step();
    checks++; if (ovld6 !== 1'b0) begin errors++; $display("FAIL range7_valid got=%b exp=0", ovld6); end
    sel6 = 3'd6;
    #1;
    checks++; if (ordy6 !== 6'h00) begin errors++; $display("FAIL range6_ready got=%h exp=00", ordy6); end
    sel6 = 3'd5;
    #1;
    checks++; if (ordy6 !== 6'h20) begin errors++; $display("FAIL range5_ready got=%h exp=20", ordy6); end
    step();
    checks++; if (odata6 !== 32'h605 || ovld6 !== 1'b1) begin errors++; $display("FAIL range5_out got=%h/%b exp=605/1", odata6, ovld6); end
    vld6 = 6'h00;
  endtask

  task automatic test_round_robin();
    int exp_g [6];
    exp_g = '{0, 4, 7, 0, 4, 7};
    for (int k = 0; k < 8; k++) set_data(k, 32'hA0 + k);
    mode = 1'b1; vld = 8'h91; rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (ordy !== (8'h01 << exp_g[i])) begin
        errors++; $display("FAIL rr_ready[%0d] got=%h exp=%h", i, ordy, 8'h01 << exp_g[i]);
      end
      step();
      checks++;
      if (odata !== (32'hA0 + exp_g[i]) || ovld !== 1'b1) begin
        errors++; $display("FAIL rr_data[%0d] got=%h/%b exp=%h/1", i, odata, ovld, 32'hA0 + exp_g[i]);
      end
    end
    vld = 8'h00;
    step();
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 3'd1; set_data(1, 32'h11); vld = 8'h02; rdy = 1'b1;
    step();
    checks++; if (odata !== 32'h11 || ovld !== 1'b1) begin errors++; $display("FAIL bp_load got=%h/%b exp=11/1", odata, ovld); end
    rdy = 1'b0; sel = 3'd2; set_data(2, 32'h22); vld = 8'h04;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) mode = 1'b1;  // mode flip must not disturb the held beat
      #1;
      checks++; if (ordy !== 8'h00) begin errors++; $display("FAIL bp_ready[%0d] got=%h exp=00", i, ordy); end
      step();
      checks++; if (odata !== 32'h11 || ovld !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got=%h/%b exp=11/1", i, odata, ovld); end
    end
    mode = 1'b0;
    rdy = 1'b1;
    #1;
    checks++; if (ordy !== 8'h04) begin errors++; $display("FAIL bp_release_ready got=%h exp=04", ordy); end
    step();
    checks++; if (odata !== 32'h22 || ovld !== 1'b1) begin errors++; $display("FAIL bp_release_data got=%h/%b exp=22/1", odata, ovld); end
    vld = 8'h00;
    step();
    checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", ovld); end
  endtask

  task automatic test_async_reset();
    // Transfer from input 3 leaves rr_ptr at 4.
    mode = 1'b1; set_data(3, 32'h33); vld = 8'h08; rdy = 1'b1;
    step();
    checks++; if (odata !== 32'h33 || ovld !== 1'b1) begin errors++; $display("FAIL ar_load got=%h/%b exp=33/1", odata, ovld); end
`ifdef MUX_N_ARB_SRC_TAG_EN
    checks++; if (osrc !== 3'd3) begin errors++; $display("FAIL src_tag got=%0d exp=3", osrc); end
`endif
    rdy = 1'b0; vld = 8'h00;
    step();
`ifdef MUX_N_ARB_SRC_TAG_EN
    checks++; if (osrc !== 3'd3) begin errors++; $display("FAIL src_hold got=%0d exp=3", osrc); end
`endif
    vld = 8'hFF;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", ovld); end
    checks++; if (odata !== 32'h0) begin errors++; $display("FAIL ar_data got=%h exp=0", odata); end
    checks++; if (ordy !== 8'h00) begin errors++; $display("FAIL ar_ready got=%h exp=00", ordy); end
`ifdef MUX_N_ARB_SRC_TAG_EN
    checks++; if (osrc !== 3'd0) begin errors++; $display("FAIL ar_src got=%0d exp=0", osrc); end
`endif
    step();
    rst = 1'b0; rdy = 1'b1;
    #1;
    checks++; if (ordy !== 8'h01) begin errors++; $display("FAIL ar_rr_restart got=%h exp=01", ordy); end
    step();
    checks++; if (odata !== 32'hA0 || ovld !== 1'b1) begin errors++; $display("FAIL ar_first_beat got=%h/%b exp=a0/1", odata, ovld); end
    vld = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_select();
    test_sel_range();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
